// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Baud divider: one tick every UART_UBRR+1 clk cycles.
  localparam int UART_UBRR = 650;

  // Level of the serial line between frames and during stop bits.
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: takes one word per valid/ready handshake and shifts it out
// LSB-first as start, data, optional parity and stop bits, one bit per baud tick.
//
// state  | meaning
// IDLE   | line high, ready for a word
// SYNC   | word latched, waiting for the first usable tick
// START  | driving the start bit (low)
// DATA   | driving data bits, LSB first
// PARITY | driving the parity bit
// STOP   | driving stop bit(s) (high)
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_tick,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam logic              ODD       = (PARITY_ODD != 0);

  uart_tx_state_t       state;
  logic [DATA_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 parity;

  // Frame sequencer; every output is registered and changes only on a tick
  // (or on accept / frame end for the handshake flags).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      parity   <= 1'b0;
      o_tx     <= UART_IDLE_LEVEL;
      o_ready  <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          // A tick arriving with the accept is deliberately ignored so the
          // start bit always gets a full tick period.
          if (i_valid && o_ready) begin
            shreg   <= i_data;
            parity  <= (^i_data) ^ ODD;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
            state   <= SYNC;
          end
        end
        SYNC: begin
          if (i_tick) begin
            o_tx  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (i_tick) begin
            o_tx    <= shreg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (i_tick) begin
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                o_tx  <= parity;
                state <= PARITY;
              end else begin
                o_tx     <= UART_IDLE_LEVEL;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              shreg   <= shreg >> 1;
              o_tx    <= shreg[1];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (i_tick) begin
            o_tx     <= UART_IDLE_LEVEL;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (i_tick) begin
            if (stop_cnt == STOP_LAST) begin
              o_done  <= 1'b1;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
              state   <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          o_tx    <= UART_IDLE_LEVEL;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter: accepts one parallel data word per valid/ready handshake and shifts it out LSB-first on a single line as start, data, optional parity and stop bits. All bit boundaries are aligned to a one-cycle baud tick from the UART baud tick generator; `i_tick` connects to the generator's TX tick output. The block sits between the host-side byte source and the UART TX pin.

## Interface
- DATA_BITS, 8, data bits per frame (5..9)
- PARITY_EN, 0, 1 = insert parity bit after data
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
- STOP_BITS, 1, number of stop bits (1 or 2)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- i_tick  input  1  baud tick, one-cycle pulse per bit period
- i_valid  input  1  host has a word to send
- i_data  input  DATA_BITS  word to send, sampled on accept
- o_ready  output  1  block can accept a word (IDLE only)
- o_tx  output  1  serial line, idle high
- o_busy  output  1  frame in progress (any state but IDLE)
- o_done  output  1  one-cycle pulse when the last stop bit completes

## Operation
- Reset (asserted, async): state IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0, shift register and counters 0. Reset mid-frame aborts it; line returns high immediately.
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- IDLE: o_ready=1. On i_valid && o_ready: latch i_data into the shift register, compute parity (XOR of data, inverted if PARITY_ODD), go to SYNC. i_tick is ignored in IDLE.
- SYNC: wait for i_tick; on tick go to START and drive o_tx=0. A tick in the same cycle as the accept is not used; SYNC waits for the next one.
- START: on tick go to DATA and drive o_tx=data[0]; bit_cnt=0.
- DATA: on tick, if bit_cnt==DATA_BITS-1, go to PARITY (o_tx=parity) when PARITY_EN=1, otherwise go to STOP (o_tx=1) with stop_cnt=0. Otherwise shift right, drive the next bit, and increment bit_cnt.
- PARITY: on tick go to STOP, drive o_tx=1, stop_cnt=0.
- STOP: on tick, if stop_cnt==STOP_BITS-1, go to IDLE and pulse o_done. Otherwise increment stop_cnt. o_tx stays 1.
- i_data and i_valid are don't-care outside IDLE. Only the latched copy is transmitted.
- bit_cnt width is $clog2(DATA_BITS); stop_cnt is 1 bit.

## Timing
- o_tx is registered. Each bit starts the cycle after the tick that selects it and lasts exactly one tick period.
- Accept-to-start latency: from the accept cycle to the first tick, plus 1 cycle. Worst case is one tick period plus 1.
- Frame length is 1 + DATA_BITS + PARITY_EN + STOP_BITS tick periods, counted from the start-bit tick to the tick that ends the last stop bit.
- o_done is asserted for the single cycle after the final STOP tick, together with o_ready=1 and o_busy=0.
- Back-to-back frames: a word can be accepted the cycle o_ready returns. Its start bit begins at the next tick, so the stop level lasts at least STOP_BITS periods, plus the part-period spent in SYNC.
- Tick period below the frame-state count is not supported. The minimum legal tick spacing is 2 clk cycles.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` {IDLE, SYNC, START, DATA, PARITY, STOP}
  - constant UART_UBRR = 650
  - constant UART_IDLE_LEVEL = 1'b1
- Single flat module with no sub-module. Parity is a one-line reduction XOR inside the module.

## Test plan
- Tick every 651 clk, default params. Send 0xA5. Expected o_tx: 0, then 1,0,1,0,0,1,0,1, then 1, each bit lasting 651 cycles. o_done pulses 6510 cycles after the start-bit edge plus 1; o_busy is high throughout the frame.
- PARITY_EN=1, PARITY_ODD=0, send 0x07. Expected parity bit = 1 and an 11-bit frame. With PARITY_ODD=1 the parity bit = 0.
- STOP_BITS=2, send 0x00. Expected: 9 low bit periods (start + 8 data), then 2 high periods, then o_done.
- i_valid held high with 0x55 then 0x33. Expected: exactly two frames, each accepted only when o_ready=1, data matching and in order, no glitch on o_tx between the frames.
- Tick coincident with the accept cycle. Expected: start bit begins one full tick period later, not in the cycle after the accept.
- Reset asserted mid-DATA. Expected: o_tx=1, o_ready=1, o_busy=0 asynchronously. After release, a new 0xFF frame transmits correctly.
